// File: rtl/da_seq_ctrl.sv
// Sequencer for the distributed-arithmetic FIR core: loads ROM coefficients, then runs sample words and returns accumulated results.
// Latency: one cycle from each handshake to the registered core strobe; accepted sample to next smp_ready is core latency + 3 cycles.
// Backpressure: cfg/smp use valid/ready; sample intake stalls while the last word of a group would overwrite an unconsumed result.
module da_seq_ctrl #(
   parameter int ITERS     = 16,
   parameter int TIMEOUT   = 15,
   parameter int ROM_DEPTH = 2048
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reload,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [18:0] cfg_data,
   input  logic        smp_valid,
   output logic        smp_ready,
   input  logic [63:0] smp_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [37:0] res_data,
   output logic [63:0] core_A,
   output logic [10:0] core_caddr,
   output logic [18:0] core_cin,
   output logic        core_cload,
   output logic        core_start,
   output logic        core_reset,
   input  logic [37:0] core_acc,
   input  logic        core_done,
   output logic        coef_loaded,
   output logic        err
);

   localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {LOAD, IDLE, RUN, CAPT} state_t;

   state_t        state, state_nxt;
   logic [10:0]   addr;
   logic [IW-1:0] iter;
   logic [CW-1:0] cnt;
   logic          armed;
   logic          last_coef;
   logic          last_iter;
   logic          timeout_hit;

   assign last_coef   = (addr == 11'(ROM_DEPTH - 1));
   assign last_iter   = (iter == IW'(ITERS - 1));
   assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= LOAD;
      else       state <= state_nxt;
   end

   // Next state and combinational ready outputs; reload beats a coincident sample
   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      smp_ready = 1'b0;
      case (state)
         LOAD: begin
            cfg_ready = armed;
            if (cfg_valid && armed && last_coef) state_nxt = IDLE;
         end
         IDLE: begin
            smp_ready = !reload && !(last_iter && res_valid);
            if (reload)                      state_nxt = LOAD;
            else if (smp_valid && smp_ready) state_nxt = RUN;
         end
         RUN: begin
            if (core_done || timeout_hit) state_nxt = CAPT;
         end
         CAPT: begin
            state_nxt = IDLE;
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Datapath: registered core strobes, address/iteration counters, watchdog and result register
   always_ff @(posedge clk) begin
      if (reset) begin
         armed       <= 1'b0;
         addr        <= '0;
         iter        <= '0;
         cnt         <= '0;
         coef_loaded <= 1'b0;
         err         <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         core_A      <= '0;
         core_caddr  <= '0;
         core_cin    <= '0;
         core_cload  <= 1'b0;
         core_start  <= 1'b0;
         core_reset  <= 1'b0;
      end else begin
         armed      <= 1'b1;
         core_cload <= 1'b0;
         core_start <= 1'b0;
         core_reset <= 1'b0;
         if (res_valid && res_ready) res_valid <= 1'b0;
         case (state)
            LOAD: begin
               if (cfg_valid && cfg_ready) begin
                  core_cload <= 1'b1;
                  core_caddr <= addr;
                  core_cin   <= cfg_data;
                  addr       <= addr + 11'd1;
                  if (last_coef) coef_loaded <= 1'b1;
               end
            end
            IDLE: begin
               if (reload) begin
                  addr        <= '0;
                  coef_loaded <= 1'b0;
               end else if (smp_valid && smp_ready) begin
                  core_A     <= smp_data;
                  core_start <= 1'b1;
                  core_reset <= (iter == '0);
                  cnt        <= '0;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (!core_done && timeout_hit) err <= 1'b1;
            end
            CAPT: begin
               // A group's last CAPT can only follow an accepted sample, so res_valid is already clear here
               if (last_iter) begin
                  res_data  <= core_acc;
                  res_valid <= 1'b1;
                  iter      <= '0;
               end else begin
                  iter <= iter + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_da_seq_ctrl.sv
// Directed bench for da_seq_ctrl with a behavioural 11-cycle core model.
// Drives and samples 1 time unit after each rising edge.
// Result back-pressure is exercised by holding res_ready low.
module tb_da_seq_ctrl;

   logic        clk;
   logic        reset = 1'b1;
   logic        reload = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [18:0] cfg_data = '0;
   logic        smp_valid = 1'b0;
   logic        smp_ready;
   logic [63:0] smp_data = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [37:0] res_data;
   logic [63:0] core_A;
   logic [10:0] core_caddr;
   logic [18:0] core_cin;
   logic        core_cload;
   logic        core_start;
   logic        core_reset;
   logic [37:0] core_acc = '0;
   logic        core_done = 1'b0;
   logic        coef_loaded;
   logic        err;

   da_seq_ctrl dut (
      .clk(clk), .reset(reset), .reload(reload),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .core_A(core_A), .core_caddr(core_caddr), .core_cin(core_cin),
      .core_cload(core_cload), .core_start(core_start), .core_reset(core_reset),
      .core_acc(core_acc), .core_done(core_done),
      .coef_loaded(coef_loaded), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: done is high exactly 11 cycles after the start cycle
   logic done_en = 1'b0;
   int   cnt_m   = 0;
   always @(posedge clk) begin
      if (core_start && done_en) cnt_m <= 10;
      else if (cnt_m > 0)        cnt_m <= cnt_m - 1;
      core_done <= (cnt_m == 1);
   end

   int n_cmp = 0;
   int n_err = 0;

   // Per-phase statistics gathered by tick()
   int   cyc = 0;
   int   n_acc, n_start, n_rst, gap_bad, a_bad, last_start, smp_target;
   logic rst_first;

   function automatic logic [63:0] pat(input int k);
      return 64'(k + 1) * 64'h9E37_79B9_7F4A_7C15;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      n_acc = 0; n_start = 0; n_rst = 0; gap_bad = 0; a_bad = 0;
      last_start = 0; rst_first = 1'b0; smp_data = pat(0);
   endtask

   task automatic tick();
      logic hs;
      hs = ((smp_valid && smp_ready) === 1'b1);
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
         n_acc++;
         smp_data = pat(n_acc);
         if (n_acc >= smp_target) smp_valid = 1'b0;
      end
      if (core_start === 1'b1) begin
         if (n_start > 0 && (cyc - last_start) != 14) gap_bad++;
         if (n_start == 0) rst_first = core_reset;
         if (core_reset === 1'b1) n_rst++;
         if (core_A !== pat(n_acc - 1)) a_bad++;
         last_start = cyc;
         n_start++;
      end
   endtask

   task automatic check_reset_vals();
      check("rst_coef_loaded", 64'(coef_loaded), 64'(0));
      check("rst_err",         64'(err),         64'(0));
      check("rst_res_valid",   64'(res_valid),   64'(0));
      check("rst_cload",       64'(core_cload),  64'(0));
      check("rst_start",       64'(core_start),  64'(0));
      check("rst_core_reset",  64'(core_reset),  64'(0));
      check("rst_smp_ready",   64'(smp_ready),   64'(0));
      check("rst_cfg_ready",   64'(cfg_ready),   64'(0));
      check("rst_caddr",       64'(core_caddr),  64'(0));
      check("rst_cin",         64'(core_cin),    64'(0));
      check("rst_core_A",      core_A,           64'(0));
      check("rst_res_data",    64'(res_data),    64'(0));
   endtask

   // Stream 2048 coefficients (value = index - 1024) with cfg_valid held high
   task automatic load_coefs();
      int          pulses;
      int          bad;
      logic [18:0] cin5;
      pulses = 0; bad = 0; cin5 = '0;
      cfg_valid = 1'b1;
      for (int i = 0; i < 2048; i++) begin
         cfg_data = 19'(i - 1024);
         @(posedge clk);
         #1;
         if (core_cload === 1'b1) pulses++;
         if (core_caddr !== 11'(i)) bad++;
         if (core_cin !== 19'(i - 1024)) bad++;
         if (coef_loaded !== (i == 2047)) bad++;
         if (i == 5) cin5 = core_cin;
      end
      cfg_valid = 1'b0;
      check("load_pulses",    64'(pulses), 64'(2048));
      check("load_addr_data", 64'(bad),    64'(0));
      check("load_cin5",      64'(cin5),   64'(19'h7FC05));
      check("load_done_flag", 64'(coef_loaded), 64'(1));
      check("load_cfg_ready_drop", 64'(cfg_ready), 64'(0));
      tick();
      check("load_cload_quiet", 64'(core_cload), 64'(0));
      check("load_cfg_ready_idle", 64'(cfg_ready), 64'(0));
   endtask

   localparam logic [37:0] ACC1 = 38'h00_0001_2345;
   localparam logic [37:0] ACC2 = 38'h3F_0000_0ABC;
   localparam logic [37:0] ACC3 = 38'h00_1555_5555;

   initial begin
      clear_stats();
      smp_target = 0;

      // Reset state
      tick(); tick();
      check_reset_vals();
      reset = 1'b0;
      tick();
      check("rel_cfg_ready", 64'(cfg_ready), 64'(1));
      check("rel_smp_ready", 64'(smp_ready), 64'(0));

      // Coefficient load
      load_coefs();
      check("idle_smp_ready", 64'(smp_ready), 64'(1));

      // Single result: 16 back-to-back samples
      core_acc = ACC1;
      done_en  = 1'b1;
      clear_stats();
      smp_target = 16;
      smp_valid  = 1'b1;
      for (int k = 0; k < 400 && res_valid !== 1'b1; k++) tick();
      check("one_res_valid", 64'(res_valid), 64'(1));
      check("one_res_data",  64'(res_data),  64'(ACC1));
      check("one_starts",    64'(n_start),   64'(16));
      check("one_gap14",     64'(gap_bad),   64'(0));
      check("one_rst_first", 64'(rst_first), 64'(1));
      check("one_rst_count", 64'(n_rst),     64'(1));
      check("one_core_A",    64'(a_bad),     64'(0));
      check("one_no_err",    64'(err),       64'(0));
      for (int k = 0; k < 5; k++) tick();
      check("one_hold_valid", 64'(res_valid), 64'(1));
      check("one_hold_data",  64'(res_data),  64'(ACC1));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("one_consumed", 64'(res_valid), 64'(0));

      // Back-pressure: 32 samples with res_ready low
      core_acc = ACC2;
      clear_stats();
      smp_target = 32;
      smp_valid  = 1'b1;
      for (int k = 0; k < 400 && res_valid !== 1'b1; k++) tick();
      check("bp_first_valid", 64'(res_valid), 64'(1));
      core_acc = ACC3;
      for (int k = 0; k < 300; k++) tick();
      check("bp_stalled_at_31", 64'(n_acc),     64'(31));
      check("bp_smp_ready_low", 64'(smp_ready), 64'(0));
      check("bp_first_intact",  64'(res_data),  64'(ACC2));
      check("bp_still_valid",   64'(res_valid), 64'(1));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("bp_first_taken", 64'(res_valid), 64'(0));
      for (int k = 0; k < 100 && res_valid !== 1'b1; k++) tick();
      check("bp_second_valid", 64'(res_valid), 64'(1));
      check("bp_second_data",  64'(res_data),  64'(ACC3));
      check("bp_all_32",       64'(n_acc),     64'(32));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Watchdog: core never finishes
      done_en = 1'b0;
      clear_stats();
      smp_target = 1;
      smp_valid  = 1'b1;
      for (int k = 0; k < 50 && n_start == 0; k++) tick();
      check("wd_started", 64'(n_start), 64'(1));
      for (int k = 0; k < 14; k++) tick();
      check("wd_err_early", 64'(err), 64'(0));
      tick();
      check("wd_err_at_15", 64'(err), 64'(1));
      tick();
      check("wd_back_idle", 64'(smp_ready), 64'(1));
      smp_target = 2;
      smp_valid  = 1'b1;
      for (int k = 0; k < 50 && n_start == 1; k++) tick();
      check("wd_iter_incr", 64'(core_reset), 64'(0));
      for (int k = 0; k < 17; k++) tick();
      check("wd_err_sticky", 64'(err),       64'(1));
      check("wd_idle_again", 64'(smp_ready), 64'(1));

      // Reset mid-run at the 7th sample of a group
      done_en    = 1'b1;
      smp_target = 7;
      smp_valid  = 1'b1;
      for (int k = 0; k < 200 && smp_valid == 1'b1; k++) tick();
      check("mr_seventh_sent", 64'(n_acc), 64'(7));
      tick(); tick(); tick();
      reset = 1'b1;
      tick(); tick();
      check_reset_vals();
      reset = 1'b0;
      tick();
      check("mr_cfg_ready", 64'(cfg_ready), 64'(1));
      load_coefs();
      clear_stats();
      smp_target = 16;
      smp_valid  = 1'b1;
      for (int k = 0; k < 400 && res_valid !== 1'b1; k++) tick();
      check("mr_res_valid", 64'(res_valid), 64'(1));
      check("mr_rst_first", 64'(rst_first), 64'(1));
      check("mr_rst_count", 64'(n_rst),     64'(1));
      check("mr_starts",    64'(n_start),   64'(16));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Reload coinciding with a sample
      clear_stats();
      smp_target = 1;
      reload     = 1'b1;
      smp_valid  = 1'b1;
      #1;
      check("rl_smp_ready_forced", 64'(smp_ready), 64'(0));
      tick();
      reload    = 1'b0;
      smp_valid = 1'b0;
      tick();
      check("rl_no_start",    64'(n_start),     64'(0));
      check("rl_coef_loaded", 64'(coef_loaded), 64'(0));
      check("rl_cfg_ready",   64'(cfg_ready),   64'(1));
      cfg_data  = 19'd123;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      check("rl_cload",  64'(core_cload), 64'(1));
      check("rl_addr0",  64'(core_caddr), 64'(0));
      check("rl_cin",    64'(core_cin),   64'(123));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded its time limit");
      $fatal(1, "time limit");
   end

endmodule
